// File: rtl/phase_sched.sv
// phase_sched: time-shares one iterative phase engine across four channels.
// Snapshots a sample set on endata, issues ch1..ch4 in order, then publishes all four phases at once.
module phase_sched #(
   parameter int TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        endata,
   input  logic [12:0] re1,
   input  logic [12:0] re2,
   input  logic [12:0] re3,
   input  logic [12:0] re4,
   input  logic [12:0] im1,
   input  logic [12:0] im2,
   input  logic [12:0] im3,
   input  logic [12:0] im4,
   input  logic        clrflags,
   output logic        eng_start,
   output logic [12:0] eng_x,
   output logic [12:0] eng_y,
   input  logic        eng_done,
   input  logic [18:0] eng_angle,
   output logic [18:0] phase1,
   output logic [18:0] phase2,
   output logic [18:0] phase3,
   output logic [18:0] phase4,
   output logic        phasevalid,
   output logic        busy,
   output logic        overrun,
   output logic        timeout_err
);

   // state | meaning
   // IDLE  | waiting for endata
   // ISSUE | eng_start pulse with operands of channel ch
   // WAIT  | operands held; waiting for eng_done or timeout
   // DONE  | phase1..phase4 published, phasevalid high
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [1:0]         ch_q;
   logic [CW-1:0]      cnt_q;
   logic [3:0][12:0]   snap_re, snap_im;
   logic [3:0][18:0]   shadow_q;

   logic accept, capture, last, tmo, drop;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      last    = 1'b0;
      tmo     = 1'b0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (endata) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            drop    = endata;
            state_d = WAIT;
         end
         WAIT: begin
            drop = endata;
            if (eng_done) begin
               capture = 1'b1;
               if (ch_q == 2'd3) begin
                  last    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
               end
            end else if (cnt_q == CNT_LAST) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end
         end
         DONE: begin
            if (endata) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign eng_start  = (state_q == ISSUE);
   assign phasevalid = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign eng_x      = snap_re[ch_q];
   assign eng_y      = snap_im[ch_q];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= 2'd0;
         cnt_q       <= '0;
         snap_re     <= '0;
         snap_im     <= '0;
         shadow_q    <= '0;
         phase1      <= '0;
         phase2      <= '0;
         phase3      <= '0;
         phase4      <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            snap_re <= {re4, re3, re2, re1};
            snap_im <= {im4, im3, im2, im1};
            ch_q    <= 2'd0;
         end else if (capture && !last) begin
            ch_q <= ch_q + 2'd1;
         end
         if (state_q == ISSUE)
            cnt_q <= '0;
         else if (state_q == WAIT)
            cnt_q <= cnt_q + 1'b1;
         if (capture)
            shadow_q[ch_q] <= eng_angle;
         else if (tmo)
            shadow_q <= '0;
         // Channel 4 goes straight from the engine so all four phases land in the DONE cycle.
         if (last) begin
            phase1 <= shadow_q[0];
            phase2 <= shadow_q[1];
            phase3 <= shadow_q[2];
            phase4 <= eng_angle;
         end
         overrun     <= drop | (overrun & ~clrflags);
         timeout_err <= tmo | (timeout_err & ~clrflags);
      end
   end

endmodule

// File: doc/phase_sched.md
# phase_sched

Scheduler that time-shares one iterative phase-calculation engine (CORDIC atan2, 19-bit 9Q10 angle) across the four transducer channels of the wind datapath. It replaces four parallel phase calculators. It snapshots the four complex samples on every `endata` strobe and issues them to the engine in fixed order. It then presents all four phases together with a one-cycle valid pulse to the phase-difference stage.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles spent waiting for `eng_done` before the sequence is aborted.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `endata`  in  1  new-sample strobe, one cycle wide.
- `re1`..`re4`, `im1`..`im4`  in  13 each  signed complex samples for channels 1–4, valid while `endata`=1.
- `clrflags`  in  1  clears the sticky flags.
- `eng_start`  out  1  one-cycle engine start pulse.
- `eng_x`, `eng_y`  out  13 each  signed engine operands; held stable from the start pulse until `eng_done`.
- `eng_done`  in  1  one-cycle result-ready pulse from the engine.
- `eng_angle`  in  19  signed 9Q10 engine result, valid with `eng_done`.
- `phase1`..`phase4`  out  19 each  signed 9Q10 phases of the last completed set.
- `phasevalid`  out  1  one-cycle pulse; `phase1`..`phase4` were updated on this cycle.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  sticky flag; a sample was dropped.
- `timeout_err`  out  1  sticky flag; the engine failed to answer within `TIMEOUT` cycles.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. A 2-bit channel index `ch` runs 0..3.
- IDLE
  - If `endata`=1: register all eight inputs into snapshot registers, set `ch`=0, go to ISSUE.
- ISSUE
  - Drive `eng_start`=1 with `eng_x`/`eng_y` = snapshot of channel `ch`+1.
  - Clear the wait counter and go to WAIT.
- WAIT
  - Hold `eng_x`/`eng_y`; the wait counter increments every cycle.
  - If `eng_done`=1: write `eng_angle` into shadow register `ch`.
    - If `ch`<3: increment `ch` and go to ISSUE.
    - If `ch`=3: go to DONE.
  - Else if the counter equals `TIMEOUT`-1: set `timeout_err` and go to IDLE.
    - `phasevalid` does not fire and `phase1`..`phase4` are unchanged.
    - The shadow registers are discarded.
- DONE
  - Copy all four shadow registers into `phase1`..`phase4` simultaneously and pulse `phasevalid`.
  - If `endata`=1 in this cycle: accept it as in IDLE and go to ISSUE.
  - Otherwise go to IDLE.
- Overrun
  - `endata`=1 while in ISSUE or WAIT sets `overrun`.
  - The dropped sample never overwrites the snapshot, and the running sequence continues unaffected.
- `eng_done` outside WAIT is ignored; it causes no capture and no state change.
- Sticky flags
  - `clrflags` clears `overrun` and `timeout_err`.
  - If a set and a clear occur in the same cycle, the set wins.
- No arithmetic is performed. The angle passes through at full 19 bits with no truncation or saturation.
- Reset values
  - Every output is 0, including `phase1`..`phase4`, `eng_x` and `eng_y`.
  - The FSM is in IDLE, `ch`=0, and the shadow, snapshot and counter registers are all 0.
- Reset mid-sequence: on the next edge the FSM is in IDLE and `eng_start`=0. Any late `eng_done` is ignored.

## Timing
- Engine latency L ≥ 1 is defined as `eng_done` arriving L cycles after the `eng_start` cycle.
- Sequence timeline, with `endata` sampled in cycle k:
  - `eng_start` for channel 1 is asserted in cycle k+1.
  - `eng_start` for channel i is asserted in cycle k+1+(i−1)(L+1).
  - `eng_done` for channel 4 arrives in cycle k+4L+4.
  - `phasevalid` is asserted in cycle k+4L+5.
- Total latency from `endata` to `phasevalid` is 4L+5 cycles.
- The minimum `endata` period with no overrun is 4L+5. A strobe arriving in the DONE cycle is accepted.
- `busy` goes high in cycle k+1 and goes low the cycle after DONE, unless DONE accepted a new sample.
- Timeout with no `eng_done`: `timeout_err` rises and the FSM is in IDLE in cycle (start cycle)+`TIMEOUT`+1.

## Test plan
- **Basic sequence.** Engine model with L=16 returning angles 0x00400, 0x7FC00, 0x01000, 0x00001 (in issue order); inputs re/im are distinct per channel.
  - Required: `eng_start` pulses with ch1..ch4 operands in order.
  - Required: `phasevalid` in cycle k+69, with `phase1`..`phase4` equal to those four values.
- **Back-to-back.** `endata` every 69 cycles with L=16.
  - Required: every sample is accepted, `overrun`=0, and `phasevalid` fires every 69 cycles.
- **Overrun.** With L=16, a second `endata` at k+10 carrying different data.
  - Required: `overrun`=1 from k+11, the first result is unchanged, and no second sequence starts.
  - Then `clrflags` → `overrun`=0.
- **Timeout.** With `TIMEOUT`=64 and the engine silent on channel 3.
  - Required: `timeout_err`=1, the FSM returns to IDLE, no `phasevalid`, and the old phases are retained.
  - A following sample completes normally.
- **Reset mid-WAIT.** Assert `reset` during the wait for channel 2, then send a late `eng_done`.
  - Required: all outputs are 0, `busy`=0, and the late `eng_done` is ignored.
- **Spurious `eng_done` in IDLE and flag priority.** Pulse `eng_done` while in IDLE, and assert `clrflags` in the same cycle as an overrun.
  - Required: the `eng_done` changes no state or phases.
  - Required: `overrun`=1, because the set wins over the clear.
